reverb_mix_n: RTL and testbench
===============================

REVERB_MIX_N -- requirements
Module: reverb_mix_n

Interface
REQ-001 The module SHALL expose parameter DATA_W, default 24, the sample width in signed Q(DATA_W-1) format.
REQ-002 The module SHALL expose parameter CHANNELS, default 2, the number of interleaved channels per frame, legal range 1..8.
REQ-003 The module SHALL expose parameter SAT_CNT_W, default 16, the width of the saturation event counter.
REQ-004 The module SHALL have the following ports: clk in 1, the only clock; rst in 1, asynchronous active-high reset.
REQ-005 The module SHALL have the following AXI-Stream slave ports:
- s_axis_tdata in DATA_W, late reflection sample
- s_axis_tdata_early in DATA_W, early reflection sample
- s_axis_tdata_input in DATA_W, dry input sample
- s_axis_tvalid in 1
- s_axis_tlast in 1, last channel of frame
- s_axis_tready out 1
REQ-006 The module SHALL have the following AXI-Stream master ports:
- m_axis_tdata out DATA_W
- m_axis_tvalid out 1
- m_axis_tlast out 1
- m_axis_tready in 1
REQ-007 The module SHALL have the following APB slave ports: s_apb_paddr in 32; s_apb_psel, s_apb_penable, s_apb_pwrite in 1; s_apb_pwdata in 32; s_apb_pready out 1 (tied 1); s_apb_prdata out 32; s_apb_pslverr out 1.

Function
REQ-008 The FSM SHALL have five states:
- IDLE: tready=1.
- SUM: s = early+late, DATA_W+1 bits.
- MUL: p = (s>>>1)*wet[ch] + in*dry[ch], 2*DATA_W+2 bits.
- SAT: y = p>>>(DATA_W-1), clipped to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- OUT: m_axis_tvalid=1; leave only on m_axis_tready.
REQ-009 A beat SHALL be accepted only in IDLE with s_axis_tvalid=1; all three data inputs and tlast are captured on that edge.
REQ-010 Latency SHALL be fixed: m_axis_tvalid rises exactly 4 clk edges after the accepting edge.
REQ-011 m_axis_tdata/tlast SHALL stay stable while tvalid=1 and tready=0; OUT→IDLE on the edge with tready=1.
REQ-012 m_axis_tlast SHALL equal the captured s_axis_tlast of the same beat (no one-beat skew).
REQ-013 When CTRL.enable=0, y SHALL equal s_axis_tdata_input unchanged (bypass), with the same latency and handshake.
REQ-014 The channel index ch SHALL increment per accepted beat, wrap CHANNELS-1→0, and reset to 0 after any beat with tlast=1.
REQ-015 If tlast=1 arrives with ch≠CHANNELS-1, or ch=CHANNELS-1 with tlast=0, STATUS.frame_err SHALL set (sticky) and ch SHALL follow REQ-014.
REQ-016 Each clipped result SHALL increment sat_cnt, which saturates at all-ones and never wraps.
REQ-017 The APB register map SHALL be as follows (write on psel&penable&pwrite; read combinational; pslverr=1 for unmapped addresses, writes there ignored):
- 0x00 CTRL: bit0 enable, bit1 soft_clear
- 0x04 STATUS RO: [3:0] ch, bit8 frame_err, [31:16] sat_cnt
- 0x10+4k WET[k], k<CHANNELS
- 0x30+4k DRY[k]
REQ-018 WET and DRY registers SHALL be DATA_W-bit signed, right-aligned in pwdata.
REQ-019 A soft_clear write SHALL, on the next edge: clear ch, frame_err, and sat_cnt; abort any in-flight beat to IDLE with tvalid=0; and clear bit1 itself. Gains SHALL be unaffected.
REQ-020 A gain write SHALL take effect for the next beat entering MUL; a beat already past MUL SHALL use its old product.

Reset
REQ-021 On rst=1, asynchronously:
- FSM=IDLE, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0
- ch=0, frame_err=0, sat_cnt=0
- CTRL=0 (bypass)
- WET[k]=2^(DATA_W-2) (0.5), DRY[k]=2^(DATA_W-2)
REQ-022 Reset mid-operation SHALL drop the in-flight beat with no output.

Structure
REQ-023 A shared package SHALL hold the state encoding, APB address offsets, and the CTRL/STATUS bit positions.
REQ-024 A single sub-module reverb_mix_sat (arithmetic shift plus clip to DATA_W, with a clip flag) SHALL be instantiated once.

Verification
REQ-025 Enable=1, WET=DRY=0.5, early=late=0x200000, in=0x100000 → y=0x180000 at edge +4.
REQ-026 early=late=0x7FFFFF, in=0x7FFFFF, WET=DRY=0x7FFFFF → y=0x7FFFFF, sat_cnt=1; the negative mirror case → y=0x800000, sat_cnt=2.
REQ-027 Hold m_axis_tready=0 for 10 cycles in OUT → tdata/tvalid stable, s_axis_tready=0; the release edge → IDLE.
REQ-028 CHANNELS=2, beats tlast=0,1,1 → third beat sets frame_err; STATUS read shows bit8=1 and ch=0.
REQ-029 Enable=0, in=0x123456 → y=0x123456 at +4; soft_clear while in MUL → no output, STATUS=0.
REQ-030 Assert rst in SAT state → tvalid=0 immediately and WET[0] reads 0x400000.

Source files
------------

// File: rtl/reverb_mix_n_pkg.sv
// Shared definitions for the reverb wet/dry mixer: FSM encoding,
// APB register offsets and CTRL/STATUS bit positions.
package reverb_mix_n_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SUM,
    ST_MUL,
    ST_SAT,
    ST_OUT
  } state_t;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_WET    = 8'h10;
  localparam logic [7:0] ADDR_DRY    = 8'h30;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_SC_BIT = 1;
  localparam int ST_CH_LSB   = 0;
  localparam int ST_FERR_BIT = 8;
  localparam int ST_SAT_LSB  = 16;

endpackage

// File: rtl/reverb_mix_sat.sv
// Arithmetic right shift of a wide product followed by a symmetric clip
// to OUT_W signed bits; o_clip flags that the clip was applied.
module reverb_mix_sat #(
  parameter int IN_W  = 50,
  parameter int SHIFT = 23,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  i_p,
  output logic signed [OUT_W-1:0] o_y,
  output logic                    o_clip
);

  logic signed [IN_W-1:0] w_sh;
  logic                   w_hi;
  logic                   w_lo;

  assign w_sh = i_p >>> SHIFT;
  // In range only when every bit above the kept field matches the sign.
  assign w_hi = !w_sh[IN_W-1] && (|w_sh[IN_W-2:OUT_W-1]);
  assign w_lo =  w_sh[IN_W-1] && !(&w_sh[IN_W-2:OUT_W-1]);
  assign o_clip = w_hi || w_lo;

  always_comb begin
    o_y = w_sh[OUT_W-1:0];
    if (w_hi)      o_y = {1'b0, {(OUT_W-1){1'b1}}};
    else if (w_lo) o_y = {1'b1, {(OUT_W-1){1'b0}}};
  end

endmodule

// File: rtl/reverb_mix_n.sv
// Per-channel reverb mixer: y = ((early+late)/2)*wet[ch] + in*dry[ch],
// one beat in flight, AXI-Stream in/out, APB control and status.
module reverb_mix_n
  import reverb_mix_n_pkg::*;
#(
  parameter int DATA_W    = 24,
  parameter int CHANNELS  = 2,
  parameter int SAT_CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [DATA_W-1:0] s_axis_tdata_early,
  input  logic [DATA_W-1:0] s_axis_tdata_input,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  input  logic [31:0]       s_apb_paddr,
  input  logic              s_apb_psel,
  input  logic              s_apb_penable,
  input  logic              s_apb_pwrite,
  input  logic [31:0]       s_apb_pwdata,
  output logic              s_apb_pready,
  output logic [31:0]       s_apb_prdata,
  output logic              s_apb_pslverr
);

  localparam int P_W = 2*DATA_W + 2;
  localparam logic [DATA_W-1:0] GAIN_HALF = DATA_W'(1) << (DATA_W-2);

  state_t                    r_state, w_next;
  logic                      r_en, r_sc, r_ferr;
  logic [3:0]                r_ch;
  logic [SAT_CNT_W-1:0]      r_sat;
  logic signed [DATA_W-1:0]  r_wet [CHANNELS];
  logic signed [DATA_W-1:0]  r_dry [CHANNELS];
  logic                      r_m_tvalid, r_m_tlast;
  logic [DATA_W-1:0]         r_m_tdata;

  logic signed [DATA_W-1:0]  r_early_p0, r_late_p0, r_in_p0;
  logic                      r_last_p0, r_byp_p0;
  logic [3:0]                r_bch_p0;
  logic signed [DATA_W:0]    r_s_p1;
  logic signed [P_W-1:0]     r_p_p2;

  logic                      w_accept, w_wr, w_map, w_ch_last, w_clip;
  logic [7:0]                w_off;
  logic [31:0]               w_rdata;
  logic [15:0]               w_sat16;
  logic signed [DATA_W-1:0]  w_wet_sel, w_dry_sel, w_y;
  logic signed [DATA_W:0]    w_shalf;
  logic signed [P_W-1:0]     w_p;
  logic                      w_unused;

  assign w_accept  = s_axis_tready && s_axis_tvalid;
  assign w_ch_last = (r_ch == 4'(CHANNELS-1));
  assign w_off     = s_apb_paddr[7:0];
  assign w_wr      = s_apb_psel && s_apb_penable && s_apb_pwrite;
  assign w_unused  = ^s_apb_pwdata;

  generate
    if (SAT_CNT_W >= 16) begin : g_sat_trunc
      assign w_sat16 = r_sat[15:0];
    end else begin : g_sat_ext
      assign w_sat16 = {{(16-SAT_CNT_W){1'b0}}, r_sat};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (r_sc) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (s_axis_tvalid) w_next = ST_SUM;
        ST_SUM:  w_next = ST_MUL;
        ST_MUL:  w_next = ST_SAT;
        ST_SAT:  w_next = ST_OUT;
        ST_OUT:  if (r_m_tvalid && m_axis_tready) w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  // A pending soft clear blocks new beats so none is silently dropped.
  always_comb begin
    s_axis_tready = (r_state == ST_IDLE) && !r_sc;
  end

  // Capture stage and arithmetic pipeline
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_late_p0  <= s_axis_tdata;
      r_early_p0 <= s_axis_tdata_early;
      r_in_p0    <= s_axis_tdata_input;
      r_last_p0  <= s_axis_tlast;
      r_bch_p0   <= r_ch;
      r_byp_p0   <= !r_en;
    end
    if (r_state == ST_SUM) r_s_p1 <= (DATA_W+1)'(r_early_p0) + (DATA_W+1)'(r_late_p0);
    if (r_state == ST_MUL) r_p_p2 <= w_p;
  end

  assign w_shalf = r_s_p1 >>> 1;
  assign w_p = P_W'(w_shalf) * P_W'(w_wet_sel) + P_W'(r_in_p0) * P_W'(w_dry_sel);

  reverb_mix_sat #(.IN_W(P_W), .SHIFT(DATA_W-1), .OUT_W(DATA_W)) u_sat (
    .i_p    (r_p_p2),
    .o_y    (w_y),
    .o_clip (w_clip)
  );

  always_comb begin
    w_rdata   = '0;
    w_map     = 1'b0;
    w_wet_sel = '0;
    w_dry_sel = '0;
    if (s_apb_paddr[31:8] == 24'd0) begin
      if (w_off == ADDR_CTRL) begin
        w_map = 1'b1;
        w_rdata[CTRL_EN_BIT] = r_en;
        w_rdata[CTRL_SC_BIT] = r_sc;
      end
      if (w_off == ADDR_STATUS) begin
        w_map = 1'b1;
        w_rdata[ST_CH_LSB +: 4]   = r_ch;
        w_rdata[ST_FERR_BIT]      = r_ferr;
        w_rdata[ST_SAT_LSB +: 16] = w_sat16;
      end
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_off == ADDR_WET + 8'(4*k)) begin
          w_map   = 1'b1;
          w_rdata = 32'(r_wet[k]);
        end
        if (w_off == ADDR_DRY + 8'(4*k)) begin
          w_map   = 1'b1;
          w_rdata = 32'(r_dry[k]);
        end
      end
    end
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_bch_p0 == 4'(k)) begin
        w_wet_sel = r_wet[k];
        w_dry_sel = r_dry[k];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en       <= 1'b0;
      r_sc       <= 1'b0;
      r_ch       <= '0;
      r_ferr     <= 1'b0;
      r_sat      <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        r_wet[k] <= GAIN_HALF;
        r_dry[k] <= GAIN_HALF;
      end
    end else begin
      if (r_sc) begin
        r_sc       <= 1'b0;
        r_ch       <= '0;
        r_ferr     <= 1'b0;
        r_sat      <= '0;
        r_m_tvalid <= 1'b0;
      end else begin
        if (w_accept) begin
          r_ch <= (s_axis_tlast || w_ch_last) ? 4'd0 : r_ch + 4'd1;
          if (s_axis_tlast != w_ch_last) r_ferr <= 1'b1;
        end
        if (r_state == ST_SAT) begin
          r_m_tdata <= r_byp_p0 ? r_in_p0 : w_y;
          r_m_tlast <= r_last_p0;
          if (!r_byp_p0 && w_clip && (r_sat != {SAT_CNT_W{1'b1}})) r_sat <= r_sat + 1'b1;
        end
        if (r_state == ST_OUT) r_m_tvalid <= !(r_m_tvalid && m_axis_tready);
      end
      if (w_wr && s_apb_paddr[31:8] == 24'd0) begin
        if (w_off == ADDR_CTRL) begin
          r_en <= s_apb_pwdata[CTRL_EN_BIT];
          r_sc <= s_apb_pwdata[CTRL_SC_BIT];
        end
        for (int k = 0; k < CHANNELS; k++) begin
          if (w_off == ADDR_WET + 8'(4*k)) r_wet[k] <= s_apb_pwdata[DATA_W-1:0];
          if (w_off == ADDR_DRY + 8'(4*k)) r_dry[k] <= s_apb_pwdata[DATA_W-1:0];
        end
      end
    end
  end

  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;
  assign s_apb_pready  = 1'b1;
  assign s_apb_prdata  = w_rdata;
  assign s_apb_pslverr = s_apb_psel && !w_map;

endmodule

// File: tb/tb_reverb_mix_n.sv
// Directed bench for reverb_mix_n: vector table for the mix arithmetic plus
// sequences for backpressure, framing errors, soft clear and reset.
module tb_reverb_mix_n;

  localparam int DW = 24;
  localparam int CH = 2;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_late, s_early, s_din;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [31:0]   paddr, pwdata, prdata;
  logic          psel, penable, pwrite, pready, pslverr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  reverb_mix_n #(.DATA_W(DW), .CHANNELS(CH), .SAT_CNT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_late), .s_axis_tdata_early(s_early), .s_axis_tdata_input(s_din),
    .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
    .m_axis_tready(m_tready),
    .s_apb_paddr(paddr), .s_apb_psel(psel), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata), .s_apb_pready(pready),
    .s_apb_prdata(prdata), .s_apb_pslverr(pslverr)
  );

  typedef struct {
    logic          en;
    logic [DW-1:0] wet, dry, early, late, din;
    logic          last;
    logic [DW-1:0] y;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    psel = 1'b1; pwrite = 1'b0; penable = 1'b1; paddr = a;
    #1;
    d = prdata;
    e = pslverr;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic set_gains(input logic en, input logic [DW-1:0] wet, input logic [DW-1:0] dry);
    apb_write(32'h00, {31'd0, en});
    for (int k = 0; k < CH; k++) begin
      apb_write(32'h10 + 32'(4*k), {8'd0, wet});
      apb_write(32'h30 + 32'(4*k), {8'd0, dry});
    end
  endtask

  task automatic start_beat(input logic [DW-1:0] e, input logic [DW-1:0] l,
                            input logic [DW-1:0] d, input logic last);
    check("beat_s_tready", {31'd0, s_tready}, 32'd1);
    s_early = e; s_late = l; s_din = d; s_tlast = last; s_tvalid = 1'b1;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_tvalid && n < 20);
  endtask

  logic [31:0] rd;
  logic        err;
  logic [DW-1:0] cap;
  logic        ok, seen;
  int          lat;

  initial begin
    vt[0] = '{1'b1, 24'h400000, 24'h400000, 24'h200000, 24'h200000, 24'h100000, 1'b0, 24'h180000};
    vt[1] = '{1'b1, 24'h400000, 24'h400000, 24'h100000, 24'h100000, 24'h000000, 1'b1, 24'h080000};
    vt[2] = '{1'b1, 24'h400000, 24'h400000, 24'hE00000, 24'hE00000, 24'hF00000, 1'b0, 24'hE80000};
    vt[3] = '{1'b0, 24'h400000, 24'h400000, 24'h7FFFFF, 24'h7FFFFF, 24'h123456, 1'b1, 24'h123456};
    vt[4] = '{1'b1, 24'h7FFFFF, 24'h000000, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0, 24'h7FFFFE};
    vt[5] = '{1'b1, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b1, 24'h7FFFFF};
    vt[6] = '{1'b1, 24'h7FFFFF, 24'h7FFFFF, 24'h800000, 24'h800000, 24'h800000, 1'b0, 24'h800000};
    vt[7] = '{1'b1, 24'h000000, 24'h400000, 24'h7FFFFF, 24'h7FFFFF, 24'h800000, 1'b1, 24'hC00000};

    rst = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; s_late = '0; s_early = '0; s_din = '0;
    m_tready = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_tdata", {8'd0, m_tdata}, 32'd0);
    check("rst_tlast", {31'd0, m_tlast}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_s_tready", {31'd0, s_tready}, 32'd1);
    apb_read(32'h00, rd, err); check("rst_ctrl", rd, 32'h0);
    apb_read(32'h04, rd, err); check("rst_status", rd, 32'h0);
    check("mapped_pslverr", {31'd0, err}, 32'd0);
    apb_read(32'h10, rd, err); check("rst_wet0", rd, 32'h00400000);
    apb_read(32'h34, rd, err); check("rst_dry1", rd, 32'h00400000);
    apb_read(32'h08, rd, err); check("unmapped_08_pslverr", {31'd0, err}, 32'd1);
    apb_read(32'h18, rd, err); check("wet2_pslverr", {31'd0, err}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      set_gains(vt[i].en, vt[i].wet, vt[i].dry);
      start_beat(vt[i].early, vt[i].late, vt[i].din, vt[i].last);
      wait_valid(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_y", i), {8'd0, m_tdata}, {8'd0, vt[i].y});
      check($sformatf("vec%0d_tlast", i), {31'd0, m_tlast}, {31'd0, vt[i].last});
      tick();
      check($sformatf("vec%0d_tvalid_drop", i), {31'd0, m_tvalid}, 32'd0);
    end
    apb_read(32'h04, rd, err); check("status_after_table", rd, 32'h00020000);

    // Frame error: tlast pattern 0,1,1 on a two-channel stream
    set_gains(1'b1, 24'h400000, 24'h400000);
    start_beat(24'h0, 24'h0, 24'h0, 1'b0); wait_valid(lat); tick();
    start_beat(24'h0, 24'h0, 24'h0, 1'b1); wait_valid(lat); tick();
    apb_read(32'h04, rd, err); check("ferr_clear_before", {31'd0, rd[8]}, 32'd0);
    start_beat(24'h0, 24'h0, 24'h0, 1'b1); wait_valid(lat); tick();
    apb_read(32'h04, rd, err);
    check("ferr_set", {31'd0, rd[8]}, 32'd1);
    check("ferr_ch", {28'd0, rd[3:0]}, 32'd0);

    // Backpressure for 10 cycles in OUT
    m_tready = 1'b0;
    start_beat(24'h200000, 24'h200000, 24'h100000, 1'b0);
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'd4);
    check("bp_y", {8'd0, m_tdata}, 32'h00180000);
    cap = m_tdata; ok = 1'b1;
    repeat (10) begin
      tick();
      if (!m_tvalid || m_tdata !== cap || s_tready) ok = 1'b0;
    end
    check("bp_stable", {31'd0, ok}, 32'd1);
    m_tready = 1'b1;
    tick();
    check("bp_release_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("bp_release_idle", {31'd0, s_tready}, 32'd1);
    start_beat(24'h0, 24'h0, 24'h0, 1'b1); wait_valid(lat); tick();

    // Soft clear issued so that it lands while the beat is in MUL
    s_early = 24'h100000; s_late = 24'h100000; s_din = 24'h123456; s_tlast = 1'b0; s_tvalid = 1'b1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 32'h00; pwdata = 32'h3;
    tick();
    s_tvalid = 1'b0; penable = 1'b1;
    tick();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    check("sc_tready_low", {31'd0, s_tready}, 32'd0);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (m_tvalid) seen = 1'b1;
    end
    check("sc_no_output", {31'd0, seen}, 32'd0);
    apb_read(32'h04, rd, err); check("sc_status", rd, 32'h0);
    apb_read(32'h00, rd, err); check("sc_ctrl_selfclear", rd, 32'h1);
    apb_read(32'h10, rd, err); check("sc_wet_kept", rd, 32'h00400000);

    // Reset asserted while the beat sits in SAT
    set_gains(1'b1, 24'h7FFFFF, 24'h7FFFFF);
    apb_read(32'h10, rd, err); check("wet0_written", rd, 32'h007FFFFF);
    start_beat(24'h100000, 24'h100000, 24'h100000, 1'b1);
    tick(); tick();
    rst = 1'b1;
    #1;
    check("rst_sat_tvalid", {31'd0, m_tvalid}, 32'd0);
    check("rst_sat_tdata", {8'd0, m_tdata}, 32'd0);
    apb_read(32'h10, rd, err); check("rst_sat_wet0", rd, 32'h00400000);
    apb_read(32'h00, rd, err); check("rst_sat_ctrl", rd, 32'h0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (m_tvalid) seen = 1'b1;
    end
    check("rst_sat_no_output", {31'd0, seen}, 32'd0);

    // Asynchronous reset while output is held valid
    m_tready = 1'b0;
    start_beat(24'h0, 24'h0, 24'h0ABCDE, 1'b0);
    wait_valid(lat);
    check("hold_valid_before_rst", {31'd0, m_tvalid}, 32'd1);
    #2 rst = 1'b1;
    #1 check("async_rst_tvalid", {31'd0, m_tvalid}, 32'd0);
    tick();
    rst = 1'b0;
    m_tready = 1'b1;

    // After reset the block is back in bypass
    start_beat(24'h7FFFFF, 24'h7FFFFF, 24'h0ABCDE, 1'b0);
    wait_valid(lat);
    check("post_rst_latency", 32'(lat), 32'd4);
    check("post_rst_bypass_y", {8'd0, m_tdata}, 32'h000ABCDE);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
